// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared constants, state encoding and weight helper for the
// class-merge arbiter (mux_arb_c1) and its round-robin search (rr_pick4).
package mux_arb_pkg;

  // Number of traffic classes / upstream FIFOs.
  localparam int NUM_CLASS = 4;

  // The class field occupies the top CLS_W bits of a word:
  // word[DATA_W-1 : DATA_W-CLS_W].
  localparam int CLS_W   = 2;
  localparam int CLS_MSB_OFS = 1;  // DATA_W-1 - CLS_MSB_OFS == DATA_W-2
  localparam int CLS_LSB_OFS = 2;  // DATA_W - CLS_LSB_OFS == LSB of field

  // Arbiter FSM: IDLE has no current grant, SERVE is bursting class cur.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SERVE = 1'b1
  } state_e;

  // Burst weight of a class; a configured weight of 0 behaves as 1 so a
  // class can never be starved by a mis-set parameter.
  function automatic int unsigned class_weight(
    input logic [CLS_W-1:0] cls,
    input int unsigned      w0,
    input int unsigned      w1,
    input int unsigned      w2,
    input int unsigned      w3
  );
    int unsigned w;
    case (cls)
      2'd0:    w = w0;
      2'd1:    w = w1;
      2'd2:    w = w2;
      default: w = w3;
    endcase
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/mux_arb_c1_rr_pick4.sv
// rr_pick4: combinational circular search for the first asserted request,
// starting at index 'start' (inclusive) and wrapping modulo 4.
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [CLS_W-1:0]     start,
  input  logic [NUM_CLASS-1:0] req,
  output logic [CLS_W-1:0]     idx,
  output logic                 found
);

  logic [CLS_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest hit is kept last.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = NUM_CLASS - 1; k >= 0; k--) begin
      cand = start + CLS_W'(k);
      if (req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_arb_c1.sv
// mux_arb_c1: weighted round-robin merge of four per-class show-ahead FIFOs
// into one registered word stream.
//
// Optional build macro: MUX_ARB_C1_STRICT_PRIO_EN
//   defined   -> class 3 preempts the WRR schedule whenever it has data; the
//                interrupted class keeps cur/credit and resumes afterwards.
//   undefined -> pure weighted round-robin, class 3 bursts W3 words.
//
// Handshake: a class FIFO offers its head word whenever fifo_empty[i]=0;
// fifo_pop[i]=1 in a cycle consumes that head at the rising edge (no ready
// back-pressure on the FIFO side). Downstream has no ready: muxout_valid=1
// means muxout holds a new word for exactly that cycle, and pause=1 stops
// all pops so no word is produced one cycle later.
module mux_arb_c1
  import mux_arb_pkg::*;
#(
  parameter int          DATA_W = 12,
  parameter int          CRED_W = 3,
  parameter int unsigned W0     = 4,
  parameter int unsigned W1     = 3,
  parameter int unsigned W2     = 2,
  parameter int unsigned W3     = 1
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic [DATA_W-1:0]    fifo_data0,
  input  logic [DATA_W-1:0]    fifo_data1,
  input  logic [DATA_W-1:0]    fifo_data2,
  input  logic [DATA_W-1:0]    fifo_data3,
  input  logic [NUM_CLASS-1:0] fifo_empty,
  input  logic                 pause,
  output logic [NUM_CLASS-1:0] fifo_pop,
  output logic [DATA_W-1:0]    muxout,
  output logic                 muxout_valid,
  output logic                 class_err,
  output state_e               dbg_state,
  output logic [CLS_W-1:0]     dbg_cur,
  output logic [CRED_W-1:0]    dbg_credit
);

  // Arbiter state.
  state_e              state_q, state_d;
  logic [CLS_W-1:0]    cur_q, cur_d;
  logic [CLS_W-1:0]    ptr_q, ptr_d;
  logic [CRED_W-1:0]   credit_q, credit_d;

  // Grant decode.
  logic [NUM_CLASS-1:0] req;
  logic [CLS_W-1:0]     scan_start;
  logic [CLS_W-1:0]     scan_idx;
  logic                 scan_found;
  logic                 keep_cur;
  logic                 grant;
  logic                 prio_hit;
  logic [CLS_W-1:0]     g;
  logic [DATA_W-1:0]    sel_word;
  logic [CRED_W-1:0]    reload;

  assign req = ~fifo_empty;

  // In SERVE the search starts just past cur (cur itself is reached last,
  // which gives the re-grant when it is the only class with data); in IDLE
  // it starts at the saved pointer.
  assign scan_start = (state_q == ST_SERVE) ? cur_q + CLS_W'(1) : ptr_q;

  rr_pick4 u_pick (
    .start (scan_start),
    .req   (req),
    .idx   (scan_idx),
    .found (scan_found)
  );

  // The current burst continues only while its FIFO has data and credit
  // remains; otherwise leftover credit is forfeited and we rotate.
  assign keep_cur = (state_q == ST_SERVE) && req[cur_q] && (credit_q != '0);

  // Select the class to pop this cycle; pause suppresses every grant.
  always_comb begin
    grant    = 1'b0;
    prio_hit = 1'b0;
    g        = cur_q;
    if (!pause) begin
`ifdef MUX_ARB_C1_STRICT_PRIO_EN
      if (req[NUM_CLASS-1]) begin
        grant    = 1'b1;
        prio_hit = 1'b1;
        g        = CLS_W'(NUM_CLASS - 1);
      end else
`endif
      if (keep_cur) begin
        grant = 1'b1;
        g     = cur_q;
      end else if (scan_found) begin
        grant = 1'b1;
        g     = scan_idx;
      end
    end
  end

  // Burst length for a freshly granted class, stored as words-after-this-one.
  // Weights larger than 2**CRED_W would wrap here, so CRED_W must cover them.
  assign reload = CRED_W'(class_weight(g, W0, W1, W2, W3) - 1);

  // FSM state register (with the burst bookkeeping that travels with it).
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q  <= ST_IDLE;
      cur_q    <= '0;
      ptr_q    <= '0;
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
    end
  end

  // FSM next state: pause and strict-priority pops leave the burst untouched.
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    ptr_d    = ptr_q;
    credit_d = credit_q;
    if (!pause) begin
      if (!grant) begin
        state_d = ST_IDLE;
        ptr_d   = cur_q + CLS_W'(1);
      end else if (prio_hit) begin
        state_d = state_q;
      end else if (keep_cur) begin
        credit_d = credit_q - CRED_W'(1);
      end else begin
        state_d  = ST_SERVE;
        cur_d    = g;
        credit_d = reload;
      end
    end
  end

  // FSM outputs: one-hot pop, forced low while reset is held; debug view.
  always_comb begin
    fifo_pop   = '0;
    if (reset_L && grant) begin
      fifo_pop = NUM_CLASS'(1) << g;
    end
    dbg_state  = state_q;
    dbg_cur    = cur_q;
    dbg_credit = credit_q;
  end

  // Head word of the granted FIFO.
  always_comb begin
    case (g)
      2'd0:    sel_word = fifo_data0;
      2'd1:    sel_word = fifo_data1;
      2'd2:    sel_word = fifo_data2;
      default: sel_word = fifo_data3;
    endcase
  end

  // Output register: capture the popped word one cycle after the pop and
  // latch any class-field mismatch (the word is still forwarded).
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      muxout       <= '0;
      muxout_valid <= 1'b0;
      class_err    <= 1'b0;
    end else begin
      muxout_valid <= grant;
      if (grant) begin
        muxout <= sel_word;
        if (sel_word[DATA_W-1-CLS_MSB_OFS+1 -: CLS_W] != g) begin
          class_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mux_arb_c1.sv
// tb_mux_arb_c1: directed + randomized bench for mux_arb_c1 with a
// turn-based reference model of the weighted round-robin schedule.
module tb_mux_arb_c1;
  import mux_arb_pkg::*;

  localparam int DW = 12;
  localparam int CW = 3;
  localparam int DEPTH = 256;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_L = 1'b0;
  logic [DW-1:0] fifo_data0, fifo_data1, fifo_data2, fifo_data3;
  logic [3:0]    fifo_empty;
  logic          pause = 1'b0;
  logic [3:0]    fifo_pop;
  logic [DW-1:0] muxout;
  logic          muxout_valid;
  logic          class_err;
  state_e        dbg_state;
  logic [1:0]    dbg_cur;
  logic [CW-1:0] dbg_credit;

  mux_arb_c1 #(.DATA_W(DW), .CRED_W(CW), .W0(4), .W1(3), .W2(2), .W3(1)) dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .fifo_data0   (fifo_data0),
    .fifo_data1   (fifo_data1),
    .fifo_data2   (fifo_data2),
    .fifo_data3   (fifo_data3),
    .fifo_empty   (fifo_empty),
    .pause        (pause),
    .fifo_pop     (fifo_pop),
    .muxout       (muxout),
    .muxout_valid (muxout_valid),
    .class_err    (class_err),
    .dbg_state    (dbg_state),
    .dbg_cur      (dbg_cur),
    .dbg_credit   (dbg_credit)
  );

  // Bench-side class FIFOs
  logic [DW-1:0] mem [4][DEPTH];
  int            hd [4];
  int            tl [4];

  // Reference model: the current turn (class, words left after this one)
  int       m_cur, m_left, m_ptr;
  bit       m_busy, m_err;
  logic [DW-1:0] m_last;

  // Scoreboard
  logic [DW-1:0] exp_q [$];
  logic [1:0]    obs_cls [$];
  int checks = 0;
  int errors = 0;

  int pat_full  [10] = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 3};
  int pat_early [8]  = '{0, 0, 1, 1, 1, 2, 2, 3};
  int pat_pause [6]  = '{0, 0, 0, 0, 1, 1};
  int pat_prio  [5]  = '{0, 0, 3, 0, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit q_empty(input int c);
    return hd[c] >= tl[c];
  endfunction

  function automatic int weight(input int c);
    int w;
    case (c)
      0: w = 4;
      1: w = 3;
      2: w = 2;
      default: w = 1;
    endcase
    return (w == 0) ? 1 : w;
  endfunction

  function automatic logic [DW-1:0] mk_word(input int c, input int k);
    logic [1:0] cc;
    cc = c[1:0];
    return {cc, 10'(k)};
  endfunction

  // Driver tasks
  task automatic push(input int c, input logic [DW-1:0] w);
    mem[c][tl[c]] = w;
    tl[c]++;
  endtask

  task automatic clear_fifos();
    for (int c = 0; c < 4; c++) begin
      hd[c] = 0;
      tl[c] = 0;
    end
  endtask

  task automatic load_all(input int n);
    for (int c = 0; c < 4; c++)
      for (int k = 0; k < n; k++) push(c, mk_word(c, c * 100 + k));
  endtask

  function automatic logic [DW-1:0] head(input int c);
    return q_empty(c) ? '0 : mem[c][hd[c]];
  endfunction

  task automatic drive_heads();
    fifo_data0 = head(0);
    fifo_data1 = head(1);
    fifo_data2 = head(2);
    fifo_data3 = head(3);
    for (int c = 0; c < 4; c++) fifo_empty[c] = q_empty(c);
  endtask

  // Which class the schedule serves this cycle (-1: none)
  function automatic int model_pick(input bit p);
    int start;
    if (p) return -1;
`ifdef MUX_ARB_C1_STRICT_PRIO_EN
    if (!q_empty(3)) return 3;
`endif
    if (m_busy && m_left > 0 && !q_empty(m_cur)) return m_cur;
    start = m_busy ? m_cur + 1 : m_ptr;
    for (int k = 0; k < 4; k++)
      if (!q_empty((start + k) % 4)) return (start + k) % 4;
    return -1;
  endfunction

  task automatic model_update(input bit p, input int g);
    if (p) return;
    if (g < 0) begin
      m_busy = 0;
      m_ptr  = (m_cur + 1) % 4;
      return;
    end
`ifdef MUX_ARB_C1_STRICT_PRIO_EN
    if (g == 3) return;
`endif
    if (m_busy && g == m_cur && m_left > 0) begin
      m_left--;
    end else begin
      m_busy = 1;
      m_cur  = g;
      m_left = weight(g) - 1;
    end
  endtask

  task automatic model_reset();
    m_cur = 0; m_ptr = 0; m_left = 0; m_busy = 0; m_err = 0; m_last = '0;
    exp_q.delete();
    obs_cls.delete();
  endtask

  // One cycle: entered and left at a falling edge
  task automatic step(input bit p);
    int            g;
    logic [3:0]    exp_pop;
    logic [DW-1:0] w;
    pause = p;
    drive_heads();
    #1;
    g = model_pick(p);
    exp_pop = (g >= 0) ? 4'(4'b0001 << g) : 4'b0000;
    chk("fifo_pop", 32'(fifo_pop), 32'(exp_pop));
    if (g >= 0) begin
      w = mem[g][hd[g]];
      hd[g]++;
      exp_q.push_back(w);
      if (w[DW-1:DW-2] != 2'(g)) m_err = 1;
    end
    model_update(p, g);
    @(posedge clk);
    #1;
    chk("muxout_valid", 32'(muxout_valid), 32'(g >= 0));
    if (g >= 0) begin
      w = exp_q.pop_front();
      m_last = w;
      chk("muxout", 32'(muxout), 32'(w));
      obs_cls.push_back(muxout[DW-1:DW-2]);
    end else begin
      chk("muxout_hold", 32'(muxout), 32'(m_last));
    end
    chk("class_err", 32'(class_err), 32'(m_err));
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_L = 1'b0;
    pause   = 1'b0;
    drive_heads();
    #1;
    chk("rst_pop", 32'(fifo_pop), 32'd0);
    chk("rst_muxout", 32'(muxout), 32'd0);
    chk("rst_valid", 32'(muxout_valid), 32'd0);
    chk("rst_class_err", 32'(class_err), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk);
    @(negedge clk);
    chk("rst_pop_hold", 32'(fifo_pop), 32'd0);
    model_reset();
    reset_L = 1'b1;
  endtask

  initial begin
    clear_fifos();
    model_reset();
    drive_heads();

    // Reset with all FIFOs loaded, then the weighted order over two rounds
    load_all(10);
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b0);
    chk("order_len", 32'(obs_cls.size()), 32'd20);
    for (int i = 0; i < 20 && i < obs_cls.size(); i++)
      chk("order_cls", 32'(obs_cls[i]), 32'(pat_full[i % 10]));

    // Class 0 runs dry after two words: credit forfeited, no bubble
    clear_fifos();
    push(0, mk_word(0, 1));
    push(0, mk_word(0, 2));
    for (int c = 1; c < 4; c++)
      for (int k = 0; k < 10; k++) push(c, mk_word(c, k));
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b0);
    for (int i = 0; i < 8 && i < obs_cls.size(); i++)
      chk("early_cls", 32'(obs_cls[i]), 32'(pat_early[i]));

    // Pause after the second class-0 word for three cycles
    clear_fifos();
    load_all(10);
    do_reset();
    step(1'b0);
    step(1'b0);
    for (int i = 0; i < 3; i++) step(1'b1);
    for (int i = 0; i < 4; i++) step(1'b0);
    chk("pause_len", 32'(obs_cls.size()), 32'd6);
    for (int i = 0; i < 6 && i < obs_cls.size(); i++)
      chk("pause_cls", 32'(obs_cls[i]), 32'(pat_pause[i]));

    // Pause and empty change together: a FIFO fills while paused, no pop
    clear_fifos();
    do_reset();
    step(1'b0);
    push(2, mk_word(2, 7));
    step(1'b1);
    step(1'b0);
    chk("pause_empty_cls", 32'(obs_cls.size() > 0 ? obs_cls[0] : 2'd0), 32'd2);

    // Wrong class field in FIFO 1: forwarded, class_err sticks
    clear_fifos();
    push(1, 12'hC05);
    push(1, mk_word(1, 3));
    push(2, mk_word(2, 4));
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b0);
    chk("err_sticky", 32'(class_err), 32'd1);
    chk("err_word", 32'(obs_cls.size() > 0 ? obs_cls[0] : 2'd0), 32'd3);

    // Randomized traffic with pauses, refills, rare bad class fields and
    // one reset in the middle of a burst
    clear_fifos();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [DW-1:0] w;
      int c;
      if (i == 200) do_reset();
      if ($urandom_range(0, 1) == 0) begin
        c = $urandom_range(0, 3);
        w = mk_word(c, $urandom_range(0, 1023));
        if ($urandom_range(0, 31) == 0) w[DW-1:DW-2] = 2'($urandom_range(0, 3));
        if (tl[c] < DEPTH) push(c, w);
      end
      step($urandom_range(0, 4) == 0);
    end

`ifdef MUX_ARB_C1_STRICT_PRIO_EN
    // Class 3 arrives mid-burst, preempts, then class 0 resumes its credit
    clear_fifos();
    for (int k = 0; k < 10; k++) push(0, mk_word(0, k));
    do_reset();
    step(1'b0);
    step(1'b0);
    push(3, mk_word(3, 9));
    for (int i = 0; i < 3; i++) step(1'b0);
    for (int i = 0; i < 5 && i < obs_cls.size(); i++)
      chk("prio_cls", 32'(obs_cls[i]), 32'(pat_prio[i]));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_arb_c1.md
Name: mux_arb_c1

Overview:
- Upstream merge point for the class-split datapath. Drains four per-class FIFOs (class 0..3, carried in word bits [11:10]) into one 12-bit stream.
- Arbitration is weighted round-robin; each class gets a burst budget.
- Issues FIFO pops and produces a registered output word with a valid flag. Sits between the class FIFOs and the shared downstream FIFO/link, and honours a downstream pause.

Parameters:
- DATA_W, 12, word width; class field is bits [DATA_W-1:DATA_W-2].
- CRED_W, 3, width of the burst-credit counter.
- W0, 4, class 0 burst weight (words per turn).
- W1, 3, class 1 burst weight.
- W2, 2, class 2 burst weight.
- W3, 1, class 3 burst weight.

Ports:
- clk  in  1  single clock, rising edge.
- reset_L  in  1  reset; asynchronous assert, active-low.
- fifo_data0..fifo_data3  in  DATA_W  head word of each class FIFO (show-ahead, valid whenever the FIFO is not empty).
- fifo_empty  in  4  per-class empty flags; bit i belongs to class i.
- pause  in  1  downstream almost-full; no pop while high.
- fifo_pop  out  4  one-hot pop to class FIFOs, combinational, at most one bit high.
- muxout  out  DATA_W  registered output word.
- muxout_valid  out  1  muxout carries a new word this cycle.
- class_err  out  1  sticky flag: a popped word's class field did not match its source FIFO index.

Behaviour:
- Reset (reset_L=0, asynchronous) forces: fifo_pop=0 (gated combinationally), muxout=0, muxout_valid=0, class_err=0, state=IDLE, ptr=0, credit=0.
- States: IDLE (no current grant) and SERVE (current class cur, remaining credit).
- Grant selection, evaluated each cycle with pause=0:
  - In SERVE with fifo_empty[cur]=0 and credit>0: g=cur.
  - Otherwise g is the first non-empty class scanning cur+1, cur+2, ... (mod 4). In IDLE the scan starts at ptr.
  - If all four FIFOs are empty: no grant; next state IDLE, ptr=cur+1 (mod 4).
- When a grant exists:
  - fifo_pop[g]=1 in the same cycle.
  - At the next edge: muxout <= fifo_data_g, muxout_valid <= 1. Latency is one cycle from pop to valid.
- Credit on a new grant (g != cur, or the state was IDLE): credit <= Wg-1, cur <= g, state SERVE. A weight of 0 is treated as 1.
- Credit on a continued grant: credit <= credit-1.
- When credit is 0, the next cycle rotates to the next non-empty class. If no other class is non-empty, cur is re-granted with credit reloaded, so there are no bubbles.
- pause=1:
  - fifo_pop=0; muxout_valid <= 0 at the next edge; muxout holds its value.
  - state, cur and credit are frozen; the burst resumes where it stopped when pause drops.
- No-grant cycle: muxout_valid <= 0; muxout holds.
- class_err: set at the edge where a popped word has bits [11:10] != g. Cleared only by reset. The word is still forwarded.
- Boundary conditions:
  - FIFO becomes empty mid-burst: the remaining credit is forfeited and the arbiter rotates.
  - pause and empty change in the same cycle: pause wins and no pop occurs.
  - Reset mid-burst: the popped word has already left the FIFO. A word registered before reset asserts is discarded by the reset.
- Throughput is one word per cycle with no idle cycles while any FIFO is non-empty and pause=0.

Optional Feature:
- Macro MUX_ARB_C1_STRICT_PRIO_EN.
- Defined: class 3 has strict priority. If fifo_empty[3]=0 and pause=0, g=3 regardless of the WRR state.
  - cur and credit of the interrupted class are held and resume after class 3 drains.
  - W3 is ignored.
- Undefined: pure WRR as above, with class 3 using W3.

Decomposition:
- Shared package mux_arb_pkg holds:
  - the class field position constants;
  - the NUM_CLASS=4 constant;
  - the state encoding (IDLE, SERVE);
  - a function returning the weight for a class index (with the 0→1 clamp).
- One sub-module, rr_pick4: combinational next-non-empty search (inputs: start index, 4-bit request; outputs: index, found).
- The counter, state machine and output register stay in the top.

Test Plan:
- Reset state: hold reset_L=0 with all FIFOs non-empty → fifo_pop=0, muxout=0, muxout_valid=0. Release reset → first pop on class 0 in the next cycle.
- Weighted order: all FIFOs preloaded with 10 words (class field correct), pause=0 → output class sequence 0,0,0,0,1,1,1,2,2,3, repeating, with muxout_valid continuously 1.
- Early empty: class 0 holds 2 words, the others full → 0,0,1,1,1,2,2,3,... with no bubble.
- Pause mid-burst: pause=1 after the second class 0 word for 3 cycles → no pops, muxout_valid=0 for 3 cycles, then 2 more class 0 words before class 1.
- Class mismatch: inject 12'hC05 into FIFO 1 → word forwarded, class_err=1 one cycle later, and it stays 1 until reset.
- Strict priority (macro defined): class 0 burst running, a class 3 word arrives → class 3 is output next, then class 0 resumes with its remaining credit.
